// File: rtl/sfifo_wr_arb.sv
// sfifo_wr_arb: round-robin arbiter sharing one sfifo write port among N_REQ valid/ready requesters
module sfifo_wr_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fifo_w_en,
  output logic [DATA_W-1:0]       fifo_din,
  input  logic                    fifo_full,
  input  logic                    fifo_overflow,
  output logic [2:0]              grant_id,
  output logic                    busy,
  output logic                    ovfl_err,
  input  logic                    clr_err
);
  localparam int PW = 8 * DATA_W;
  typedef enum logic {IDLE, GRANT} state_e;
  state_e          state_q, state_d;
  logic [2:0]      grant_q, grant_d, rr_q, rr_d, sel, nxt;
  logic [7:0]      beat_q, beat_d;
  logic            ovfl_q, ovfl_d, found, xfer, rel;
  logic [3:0]      idx;
  logic [7:0]      valid_pad, last_pad;
  logic [PW-1:0]   data_pad;
  assign valid_pad = 8'(req_valid);
  assign last_pad  = 8'(req_last);
  assign data_pad  = PW'(req_data);
  // first valid requester at or above rr_q, wrapping at N_REQ
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_q} + 4'(k);
      idx = (idx >= 4'(N_REQ)) ? idx - 4'(N_REQ) : idx;
      if (!found && valid_pad[idx[2:0]]) begin
        found = 1'b1;
        sel   = idx[2:0];
      end
    end
  end
  assign busy      = (state_q == GRANT);
  assign xfer      = busy & valid_pad[grant_q] & ~fifo_full & rst;
  assign rel       = xfer & (last_pad[grant_q] | (beat_q == 8'(MAX_BURST - 1)));
  assign nxt       = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
  assign fifo_w_en = xfer;
  assign fifo_din  = xfer ? data_pad[grant_q*DATA_W +: DATA_W] : '0;
  assign grant_id  = grant_q;
  assign ovfl_err  = ovfl_q;
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) req_ready[i] = busy & ~fifo_full & (grant_q == 3'(i));
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    ovfl_d  = fifo_overflow | (ovfl_q & ~clr_err);
    if (state_q == IDLE) begin
      state_d = found ? GRANT : IDLE;
      grant_d = found ? sel : grant_q;
      beat_d  = found ? 8'd0 : beat_q;
    end else if (xfer) begin
      beat_d  = beat_q + 8'd1;
      state_d = rel ? IDLE : GRANT;
      rr_d    = rel ? nxt : rr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      ovfl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      ovfl_q  <= ovfl_d;
    end
  end
endmodule

// File: tb/tb_sfifo_wr_arb.sv
// tb_sfifo_wr_arb: directed bench with per-requester stream queues and an expected-write scoreboard
module tb_sfifo_wr_arb;
  localparam int N = 4;
  localparam int W = 8;
  logic         clk = 1'b0, rst = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic         fifo_w_en, fifo_full = 1'b0, fifo_overflow = 1'b0, clr_err = 1'b0;
  logic [W-1:0] fifo_din;
  logic [2:0]   grant_id;
  logic         busy, ovfl_err;
  int checks = 0, errors = 0, cyc = 0;
  logic [8:0]  rq [N][$];
  logic [10:0] exp_q[$];
  int          wt[$];
  logic [N-1:0] acc = '0;

  sfifo_wr_arb #(.N_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_w_en(fifo_w_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .fifo_overflow(fifo_overflow), .grant_id(grant_id), .busy(busy), .ovfl_err(ovfl_err),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  task automatic upd();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = rq[i].size() > 0;
      req_data[i*W +: W] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
      req_last[i]        = rq[i].size() > 0 ? rq[i][0][8] : 1'b0;
    end
  endtask

  task automatic push(input int r, input logic last, input logic [7:0] d);
    rq[r].push_back({last, d});
  endtask

  task automatic ex(input logic [2:0] g, input logic [7:0] d);
    exp_q.push_back({g, d});
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    acc = req_valid & req_ready;
    if (fifo_w_en) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(fifo_w_en), 32'd0);
      else chk("wr", 32'({grant_id, fifo_din}), 32'(exp_q.pop_front()));
      wt.push_back(cyc);
    end
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    upd();
  end

  initial begin
    push(0, 1, 8'h10); push(0, 1, 8'h14);
    push(1, 1, 8'h11); push(1, 1, 8'h15);
    push(2, 1, 8'h12); push(3, 1, 8'h13);
    upd();
    ex(0, 8'h10); ex(1, 8'h11); ex(2, 8'h12); ex(3, 8'h13); ex(0, 8'h14); ex(1, 8'h15);
    repeat (4) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wen", 32'(fifo_w_en), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
    end
    chk("rst_ovfl", 32'(ovfl_err), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    drive_edge();
    rst = 1'b1;
    @(negedge clk);
    chk("arb_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_gid", 32'(grant_id), 32'd0);
    wait_done("rr_done", 40);
    chk("rr_count", 32'(wt.size()), 32'd6);
    for (int k = 1; k < wt.size(); k++) chk("rr_gap", 32'(wt[k] - wt[k-1]), 32'd2);

    wt.delete();
    drive_edge();
    push(2, 0, 8'h75); push(2, 0, 8'h76); push(2, 1, 8'h77);
    upd();
    ex(2, 8'h75); ex(2, 8'h76); ex(2, 8'h77);
    wait_done("single_done", 20);
    @(negedge clk);
    chk("single_bubble", 32'(busy), 32'd0);
    chk("single_count", 32'(wt.size()), 32'd3);
    for (int k = 1; k < wt.size(); k++) chk("single_gap", 32'(wt[k] - wt[k-1]), 32'd1);

    drive_edge();
    push(0, 1, 8'hA0); push(3, 1, 8'hA3);
    upd();
    ex(3, 8'hA3); ex(0, 8'hA0);
    wait_done("rrptr_done", 20);

    drive_edge();
    for (int b = 0; b < 6; b++) push(1, b == 5, 8'(8'hB0 + b));
    push(3, 1, 8'hC3);
    upd();
    ex(1, 8'hB0); ex(1, 8'hB1); ex(1, 8'hB2); ex(1, 8'hB3);
    ex(3, 8'hC3); ex(1, 8'hB4); ex(1, 8'hB5);
    wait_done("burst_done", 40);

    wt.delete();
    drive_edge();
    for (int b = 0; b < 4; b++) push(0, b == 3, 8'(8'h40 + b));
    upd();
    for (int b = 0; b < 4; b++) ex(0, 8'(8'h40 + b));
    begin
      int n = 0;
      while (wt.size() == 0 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    chk("bp_start", 32'(wt.size()), 32'd1);
    drive_edge();
    fifo_full = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_wen", 32'(fifo_w_en), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_gid", 32'(grant_id), 32'd0);
    end
    drive_edge();
    fifo_full = 1'b0;
    @(negedge clk);
    chk("bp_resume", 32'(fifo_w_en), 32'd1);
    wait_done("bp_done", 20);

    drive_edge();
    fifo_overflow = 1'b1;
    @(negedge clk);
    chk("err_pre", 32'(ovfl_err), 32'd0);
    drive_edge();
    fifo_overflow = 1'b0;
    @(negedge clk);
    chk("err_set", 32'(ovfl_err), 32'd1);
    @(negedge clk);
    chk("err_hold", 32'(ovfl_err), 32'd1);
    drive_edge();
    clr_err = 1'b1;
    fifo_overflow = 1'b1;
    drive_edge();
    fifo_overflow = 1'b0;
    @(negedge clk);
    chk("err_setwins", 32'(ovfl_err), 32'd1);
    drive_edge();
    clr_err = 1'b0;
    @(negedge clk);
    chk("err_clr", 32'(ovfl_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfifo_wr_arb.md
Name: sfifo_wr_arb

Overview:
Round-robin write arbiter that shares one sfifo write port among N_REQ requesters.
Each requester presents a valid/ready stream with a packet-end marker. The arbiter grants one requester at a time and holds the grant until packet end or burst limit. It gates writes with the FIFO full flag and records FIFO overflow as a sticky error.
Sits directly in front of sfifo, driving its w_en/din and observing its full/overflow outputs.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width, matches sfifo din
MAX_BURST, 4, maximum beats per grant (1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low
req_valid  input  N_REQ  per-requester data valid
req_data  input  N_REQ*DATA_W  per-requester data; requester i occupies bits [i*DATA_W +: DATA_W]
req_last  input  N_REQ  per-requester final beat of packet
req_ready  output  N_REQ  per-requester accept
fifo_w_en  output  1  to sfifo w_en
fifo_din  output  DATA_W  to sfifo din
fifo_full  input  1  from sfifo full
fifo_overflow  input  1  from sfifo overflow
grant_id  output  3  index of current grantee; valid while busy=1
busy  output  1  FSM in GRANT
ovfl_err  output  1  sticky overflow flag
clr_err  input  1  clears ovfl_err

Behaviour:
- Reset: rst sampled low at a rising edge resets all state. Results: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0, ovfl_err=0. While state=IDLE, req_ready=0, fifo_w_en=0 and fifo_din=0.
- Reset mid-packet aborts the grant. No partial-beat write occurs in the reset cycle because fifo_w_en is forced to 0 while rst=0.
- FSM states are IDLE and GRANT. Registered: state, grant_id, rr_ptr, beat_cnt, ovfl_err.
- IDLE: if any req_valid is 1, select the first asserted index searching upward from rr_ptr with wrap N_REQ-1 -> 0. At the next edge, load grant_id with that index, clear beat_cnt and enter GRANT. Arbitration latency is 1 cycle: no data is accepted in the IDLE cycle.
- GRANT, combinational outputs, with g = grant_id:
  - req_ready[g] = ~fifo_full; all other req_ready bits = 0.
  - A beat transfers when req_valid[g] & req_ready[g].
  - fifo_w_en = transfer; fifo_din = req_data slice g when transferring, else 0.
- Beat transfer: beat_cnt increments.
- Release condition: a transfer with req_last[g]=1, or a transfer with beat_cnt = MAX_BURST-1.
- On release: rr_ptr <= (g+1) mod N_REQ, state <= IDLE. This gives exactly one bubble cycle between grants.
- Grant is held while req_valid[g]=0 or fifo_full=1. There is no timeout; requesters must complete started packets.
- A packet longer than MAX_BURST is split. The requester re-arbitrates for the remainder and loses priority to others.
- fifo_w_en is never asserted while fifo_full=1, so the arbiter itself never causes overflow.
- ovfl_err: set on any cycle fifo_overflow=1; cleared when clr_err=1. If set and clear occur together, set wins.
- grant_id width is fixed at 3. Upper bits are 0 when N_REQ<8.

Test Plan:
- Reset hold: rst=0 for 4 cycles with all req_valid=1 -> busy=0, fifo_w_en=0, req_ready=0. The first grant goes to req 0 one cycle after rst rises.
- Single requester: req 2 sends 3 beats 0x75,0x76,0x77 with last on 0x77, FIFO not full -> grant_id=2. fifo_w_en is high for 3 consecutive cycles with those values, then 1 IDLE cycle, rr_ptr=3.
- Round robin: all 4 requesters send 1-beat packets continuously -> grant order 0,1,2,3,0,1. Each grant is 1 write cycle plus 1 bubble.
- Burst limit: MAX_BURST=4, req 1 sends a 6-beat packet -> 4 writes, release, rr_ptr=2. With req 3 also valid, req 3 is served next, then req 1 writes its remaining 2 beats.
- Backpressure: fifo_full=1 for 3 cycles mid-packet -> req_ready[g]=0 and fifo_w_en=0 for those 3 cycles, grant retained, no data lost or duplicated. Writes resume on the cycle after full drops.
- Error flag: pulse fifo_overflow=1 for one cycle -> ovfl_err=1 next cycle and holds. Drive clr_err=1 and fifo_overflow=1 together -> ovfl_err stays 1. clr_err alone -> ovfl_err=0.
